// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with per-entry saturating direction
//   counters, used by the IF stage to choose the next fetch PC.
//
//   Ports
//     clk_i, rst_i           clock, synchronous active-high reset
//     lookup_pc_i            fetch PC (IF stage)
//     hit_o                  lookup PC matches a valid entry
//     pred_taken_o           predicted direction
//     pred_next_pc_o         predicted next fetch PC
//     upd_*_i                resolved branch from the ID stage
//     clear_i                invalidate the whole table
//     mispredict_o           presented update was mispredicted (combinational)
//     upd_count_o            accepted updates, saturating
//     mispred_count_o        mispredicted updates, saturating
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_next_pc_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  input  logic              clear_i,
  output logic              mispredict_o,
  output logic [STAT_W-1:0] upd_count_o,
  output logic [STAT_W-1:0] mispred_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_WT   = CNT_ONE << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_WT - CNT_ONE;
  localparam logic [STAT_W-1:0] STAT_ONE = 1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_d    [ENTRIES];
  logic [STAT_W-1:0]  upd_count_q, upd_count_d;
  logic [STAT_W-1:0]  mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;

  // Byte offset within the word never participates in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx  = lookup_pc_i[IDX_W+1:2];
  assign lk_tag  = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

  // Lookup reads the registered table only: a same-cycle update is not bypassed.
  assign hit_o          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o   = hit_o && cnt_q[lk_idx][CNT_W-1];
  assign pred_next_pc_o = pred_taken_o ? target_q[lk_idx] : lookup_pc_i + ADDR_W'(4);

  assign mispredict_o = upd_valid_i &&
                        ((upd_pred_taken_i != upd_taken_i) ||
                         (upd_taken_i && (upd_pred_target_i != upd_target_i)));

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;

    if (clear_i) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++) cnt_d[i] = CNT_WNT;
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          target_d[upd_idx] = upd_target_i;
          if (cnt_q[upd_idx] != CNT_MAX) cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_ONE;
        end else if (cnt_q[upd_idx] != '0) begin
          cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_ONE;
        end
      end else if (upd_taken_i) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target_i;
        cnt_d[upd_idx]    = CNT_WT;
      end
    end
  end

  // Statistics count every presented update, including ones that clear_i discards.
  always_comb begin
    upd_count_d     = upd_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_valid_i) begin
      if (upd_count_q != STAT_MAX) upd_count_d = upd_count_q + STAT_ONE;
      if (mispredict_o && (mispred_count_q != STAT_MAX))
        mispred_count_d = mispred_count_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q         <= '0;
      upd_count_q     <= '0;
      mispred_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
    end else begin
      valid_q         <= valid_d;
      cnt_q           <= cnt_d;
      upd_count_q     <= upd_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset; the update
  // still has to be suppressed during reset so a dropped update leaves no trace.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  assign upd_count_o     = upd_count_q;
  assign mispred_count_o = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] lookup_pc_i = 32'h0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = 32'h0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = 32'h0;
  logic        upd_pred_taken_i = 1'b0;
  logic [31:0] upd_pred_target_i = 32'h0;
  logic        clear_i = 1'b0;

  logic        hit_a, pt_a, mis_a;
  logic [31:0] npc_a;
  logic [15:0] uc_a, mc_a;
  logic        hit_b, pt_b, mis_b;
  logic [31:0] npc_b;
  logic [3:0]  uc_b, mc_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk_i(clk), .rst_i(rst_i), .lookup_pc_i(lookup_pc_i),
    .hit_o(hit_a), .pred_taken_o(pt_a), .pred_next_pc_o(npc_a),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i), .clear_i(clear_i),
    .mispredict_o(mis_a), .upd_count_o(uc_a), .mispred_count_o(mc_a)
  );

  branch_predictor #(.STAT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .lookup_pc_i(lookup_pc_i),
    .hit_o(hit_b), .pred_taken_o(pt_b), .pred_next_pc_o(npc_b),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i), .clear_i(clear_i),
    .mispredict_o(mis_b), .upd_count_o(uc_b), .mispred_count_o(mc_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table as plain integer arrays, statistics as unbounded
  // counts clipped to the counter width when compared.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  int          m_upd = 0;
  int          m_mis = 0;

  function automatic int clip(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(negedge clk) begin
    int          li, ui;
    bit          lhit, lpt, mis, uhit;
    logic [31:0] lnpc;
    if (rst_i) begin
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_cnt[i] = 1; end
      m_upd = 0; m_mis = 0;
    end else begin
      li   = (lookup_pc_i >> 2) % 16;
      lhit = m_valid[li] && (m_tag[li] == (lookup_pc_i >> 6));
      lpt  = lhit && (m_cnt[li] >= 2);
      lnpc = lpt ? m_tgt[li] : lookup_pc_i + 32'd4;
      mis  = upd_valid_i && ((upd_pred_taken_i != upd_taken_i) ||
                             (upd_taken_i && upd_pred_target_i != upd_target_i));
      chk("hit", hit_a, lhit);           chk("hit4", hit_b, lhit);
      chk("pred_taken", pt_a, lpt);      chk("pred_taken4", pt_b, lpt);
      chk("pred_next_pc", npc_a, lnpc);  chk("pred_next_pc4", npc_b, lnpc);
      chk("mispredict", mis_a, mis);     chk("mispredict4", mis_b, mis);
      chk("upd_count", uc_a, clip(m_upd, 65535));
      chk("mispred_count", mc_a, clip(m_mis, 65535));
      chk("upd_count4", uc_b, clip(m_upd, 15));
      chk("mispred_count4", mc_b, clip(m_mis, 15));

      if (upd_valid_i) begin
        m_upd++;
        if (mis) m_mis++;
      end
      ui   = (upd_pc_i >> 2) % 16;
      uhit = m_valid[ui] && (m_tag[ui] == (upd_pc_i >> 6));
      if (clear_i) begin
        for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_cnt[i] = 1; end
      end else if (upd_valid_i) begin
        if (uhit) begin
          if (upd_taken_i) begin
            m_tgt[ui] = upd_target_i;
            if (m_cnt[ui] < 3) m_cnt[ui]++;
          end else if (m_cnt[ui] > 0) m_cnt[ui]--;
        end else if (upd_taken_i) begin
          m_valid[ui] = 1; m_tag[ui] = upd_pc_i >> 6;
          m_tgt[ui] = upd_target_i; m_cnt[ui] = 2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg);
    upd_valid_i = 1'b1; upd_pc_i = pc; upd_taken_i = tk; upd_target_i = tg;
    upd_pred_taken_i = ptk; upd_pred_target_i = ptg;
  endtask

  task automatic idle();
    upd_valid_i = 1'b0; clear_i = 1'b0;
  endtask

  function automatic logic [31:0] rpc();
    return {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    tick(); tick();
    rst_i = 1'b0;
    lookup_pc_i = 32'h40; #1;
    chk("lit_reset_hit", hit_a, 0);
    chk("lit_reset_pt", pt_a, 0);
    chk("lit_reset_npc", npc_a, 32'h44);
    chk("lit_reset_uc", uc_a, 0);
    chk("lit_reset_mc", mc_a, 0);

    upd(32'h40, 1, 32'h100, 0, 32'h44); #1;
    chk("lit_train_mis", mis_a, 1);
    tick(); idle(); #1;
    chk("lit_train_hit", hit_a, 1);
    chk("lit_train_pt", pt_a, 1);
    chk("lit_train_npc", npc_a, 32'h100);
    chk("lit_train_mc", mc_a, 1);

    upd(32'h40, 1, 32'h100, 1, 32'h100); tick(); tick();
    upd(32'h40, 0, 32'h0, 1, 32'h100);   tick(); tick();
    idle(); #1;
    chk("lit_dec_hit", hit_a, 1);
    chk("lit_dec_pt", pt_a, 0);
    chk("lit_dec_npc", npc_a, 32'h44);

    upd(32'h40, 1, 32'h100, 0, 32'h44); #1;
    chk("lit_same_cycle_pt", pt_a, 0);
    tick(); idle(); #1;
    chk("lit_next_cycle_pt", pt_a, 1);

    lookup_pc_i = 32'h440; #1;
    chk("lit_alias_miss", hit_a, 0);
    upd(32'h440, 1, 32'h200, 0, 32'h444); tick(); idle(); #1;
    chk("lit_alias_npc", npc_a, 32'h200);
    lookup_pc_i = 32'h40; #1;
    chk("lit_alias_evict", hit_a, 0);

    upd(32'h80, 0, 32'h0, 0, 32'h84); tick(); idle();
    lookup_pc_i = 32'h80; #1;
    chk("lit_nt_noalloc", hit_a, 0);

    upd(32'h40, 1, 32'h100, 0, 32'h44); clear_i = 1'b1; tick(); idle();
    lookup_pc_i = 32'h40; #1;
    chk("lit_clear_40", hit_a, 0);
    lookup_pc_i = 32'h440; #1;
    chk("lit_clear_440", hit_a, 0);
    chk("lit_clear_uc", uc_a, 9);

    for (int c = 0; c < 400; c++) begin
      lookup_pc_i       = rpc();
      upd_valid_i       = $urandom_range(0, 1);
      upd_pc_i          = rpc();
      upd_taken_i       = $urandom_range(0, 1);
      upd_target_i      = rpc();
      upd_pred_taken_i  = $urandom_range(0, 1);
      upd_pred_target_i = $urandom_range(0, 1) ? upd_target_i : rpc();
      clear_i           = ($urandom_range(0, 15) == 0);
      rst_i             = ($urandom_range(0, 63) == 0);
      tick();
    end

    idle(); rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      upd(rpc(), 1, 32'h300, 0, 32'h0); tick();
    end
    idle(); #1;
    chk("lit_sat_uc4", uc_b, 15);
    chk("lit_sat_mc4", mc_b, 15);
    chk("lit_sat_uc16", uc_a, 20);
    tick(); #1;
    chk("lit_sat_hold_uc4", uc_b, 15);
    chk("lit_sat_hold_mc4", mc_b, 15);
    rst_i = 1'b1; tick(); rst_i = 1'b0; #1;
    chk("lit_rst_uc4", uc_b, 0);
    chk("lit_rst_mc4", mc_b, 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
